// File: rtl/td4_loader.sv
// td4_loader: UART (8N1) framed program loader into a 16x8 RAM that the TD4 core fetches from combinationally.
// Effects land one clk after byte_valid; no backpressure on rx. Define TD4_LOADER_CHECKSUM_EN to add the checksum byte.
module td4_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_reset,
  output logic       load_done,
  output logic       load_err
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    WAIT_SYNC, GET_COUNT, GET_DATA, RUN
`ifdef TD4_LOADER_CHECKSUM_EN
    , GET_SUM
`endif
  } state_t;

  rx_state_t     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [7:0]    sum_q, sum_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic          ram_we;
  logic [7:0]    ram_q [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid start bit was a glitch.
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d   = '0;
          byte_vld_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      if (ram_we) ram_q[ptr_q[3:0]] <= shift_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    ram_we      = 1'b0;
    if (frame_err_q) begin
      // A running core is never disturbed by line noise.
      if (state_q != RUN) begin
        load_err_d = 1'b1;
        state_d    = WAIT_SYNC;
      end
    end else if (byte_vld_q) begin
      case (state_q)
        WAIT_SYNC, RUN: begin
          if (shift_q == SYNC_BYTE) begin
            state_d     = GET_COUNT;
            cpu_reset_d = 1'b1;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
          end
        end
        GET_COUNT: begin
          if (shift_q <= 8'd16) begin
            cnt_d   = (shift_q == 8'd0) ? 5'd16 : shift_q[4:0];
            ptr_d   = '0;
            sum_d   = '0;
            state_d = GET_DATA;
          end else begin
            load_err_d = 1'b1;
            state_d    = WAIT_SYNC;
          end
        end
        GET_DATA: begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 5'd1;
          sum_d  = sum_q + shift_q;
          if (ptr_q + 5'd1 == cnt_q) begin
`ifdef TD4_LOADER_CHECKSUM_EN
            state_d     = GET_SUM;
`else
            state_d     = RUN;
            cpu_reset_d = 1'b0;
            load_done_d = 1'b1;
`endif
          end
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        GET_SUM: begin
          if (shift_q == sum_q) begin
            state_d     = RUN;
            cpu_reset_d = 1'b0;
            load_done_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
            state_d    = WAIT_SYNC;
          end
        end
`endif
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  assign cpu_data  = ram_q[cpu_addr];
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_td4_loader.sv
// Bench for td4_loader: directed UART frames, expected outputs queued per byte and checked by a separate monitor.
module tb_td4_loader;
  localparam int CPB = 8;
`ifdef TD4_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_reset;
  logic       load_done;
  logic       load_err;

  always #5 clk = ~clk;

  td4_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
  );

  typedef struct packed {
    logic             rst;
    logic             done;
    logic             err;
    logic             chkram;
    logic [15:0][7:0] ram;
  } exp_t;

  exp_t             expq [$];
  string            tagq [$];
  logic [15:0][7:0] e_ram;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               chk_cnt  = 0;

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: one expectation per DUT byte/framing event, checked the cycle after it.
  initial begin : monitor
    logic  armed;
    int    seen;
    exp_t  ex;
    string t;
    armed    = 1'b0;
    seen     = 0;
    cpu_addr = 4'd0;
    forever begin
      @(negedge clk);
      if (armed || (chk_cnt != seen)) begin
        armed = 1'b0;
        seen  = chk_cnt;
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: DUT produced an output event with no expectation queued");
        end else begin
          ex = expq.pop_front();
          t  = tagq.pop_front();
          check1({t, ".cpu_reset"}, {7'd0, cpu_reset}, {7'd0, ex.rst});
          check1({t, ".load_done"}, {7'd0, load_done}, {7'd0, ex.done});
          check1({t, ".load_err"},  {7'd0, load_err},  {7'd0, ex.err});
          if (ex.chkram) begin
            for (int i = 0; i < 16; i++) begin
              cpu_addr = 4'(i);
              #1;
              check1($sformatf("%s.ram[%0d]", t, i), cpu_data, ex.ram[i]);
            end
          end
        end
      end
      if (dut.byte_vld_q || dut.frame_err_q) armed = 1'b1;
    end
  end

  task automatic push_exp(input logic r, input logic d, input logic e, input logic cr, input string t);
    exp_t x;
    x = '{rst: r, done: d, err: e, chkram: cr, ram: e_ram};
    expq.push_back(x);
    tagq.push_back(t);
  endtask

  task automatic rx_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop_bit);
  endtask

  task automatic sb(input logic [7:0] b, input logic r, input logic d, input logic e, input logic cr, input string t);
    push_exp(r, d, e, cr, t);
    send_byte(b, 1'b1);
  endtask

  // Last data byte: with a checksum the load is still pending, without one it completes.
  task automatic sb_last(input logic [7:0] b, input string t);
    sb(b, CK, !CK, 1'b0, 1'b1, t);
  endtask

  // Checksum byte: without the feature the core is already running and the byte is ignored.
  task automatic sb_sum(input logic [7:0] b, input logic good, input string t);
    if (good) sb(b, 1'b0, 1'b1, 1'b0, 1'b1, t);
    else      sb(b, CK, !CK, CK, 1'b1, t);
  endtask

  task automatic wait_drain(input int max_cyc, input string t);
    int n;
    n = 0;
    while (expq.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      n_checks++;
      $display("FAIL %s.timeout: %0d expectations still pending, required 0", t, expq.size());
      expq.delete();
      tagq.delete();
    end
  endtask

  initial begin
    rx     = 1'b1;
    reset  = 1'b1;
    e_ram  = '0;
    repeat (3) @(posedge clk);
    #1;
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, "reset_state");
    chk_cnt++;
    wait_drain(20, "reset_state");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // Good load of three bytes.
    sb(8'hA5, 1, 0, 0, 0, "good.sync");
    sb(8'h03, 1, 0, 0, 0, "good.count");
    e_ram[0] = 8'h12; sb(8'h12, 1, 0, 0, 0, "good.d0");
    e_ram[1] = 8'h34; sb(8'h34, 1, 0, 0, 0, "good.d1");
    e_ram[2] = 8'h56; sb_last(8'h56, "good.d2");
    sb_sum(8'h9C, 1'b1, "good.sum");

    // Reload from RUN, then a bad checksum, then a good one-byte frame.
    sb(8'hA5, 1, 0, 0, 0, "badsum.sync");
    sb(8'h03, 1, 0, 0, 0, "badsum.count");
    sb(8'h12, 1, 0, 0, 0, "badsum.d0");
    sb(8'h34, 1, 0, 0, 0, "badsum.d1");
    sb_last(8'h56, "badsum.d2");
    sb_sum(8'h9D, 1'b0, "badsum.sum");
    sb(8'hA5, 1, 0, 0, 0, "one.sync");
    sb(8'h01, 1, 0, 0, 0, "one.count");
    e_ram[0] = 8'h7F; sb_last(8'h7F, "one.d0");
    sb_sum(8'h7F, 1'b1, "one.sum");

    // Count byte 0 means sixteen entries.
    sb(8'hA5, 1, 0, 0, 0, "n16.sync");
    sb(8'h00, 1, 0, 0, 0, "n16.count");
    for (int i = 0; i < 16; i++) begin
      e_ram[i] = 8'(i + 1);
      if (i == 15) sb_last(8'(i + 1), "n16.d15");
      else         sb(8'(i + 1), 1, 0, 0, 0, "n16.data");
    end
    sb_sum(8'h88, 1'b1, "n16.sum");

    // Count 17 aborts; following bytes must be ignored in WAIT_SYNC.
    sb(8'hA5, 1, 0, 0, 0, "badcnt.sync");
    sb(8'h11, 1, 0, 1, 0, "badcnt.count");
    sb(8'h03, 1, 0, 1, 0, "badcnt.ign0");
    sb(8'h05, 1, 0, 1, 1, "badcnt.ign1");

    // Framing error mid-data, then a short low glitch.
    sb(8'hA5, 1, 0, 0, 0, "ferr.sync");
    sb(8'h02, 1, 0, 0, 0, "ferr.count");
    e_ram[0] = 8'hAA; sb(8'hAA, 1, 0, 0, 1, "ferr.d0");
    push_exp(1'b1, 1'b0, 1'b1, 1'b1, "ferr.stop0");
    send_byte(8'h55, 1'b0);
    rx_bit(1'b1);
    repeat (20) @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    push_exp(1'b1, 1'b0, 1'b1, 1'b1, "glitch");
    chk_cnt++;
    wait_drain(20, "glitch");

    // Load, reload while running, then reset mid-frame.
    sb(8'hA5, 1, 0, 0, 0, "rl.sync");
    sb(8'h01, 1, 0, 0, 0, "rl.count");
    e_ram[0] = 8'h33; sb_last(8'h33, "rl.d0");
    sb_sum(8'h33, 1'b1, "rl.sum");
    sb(8'hA5, 1, 0, 0, 1, "rl.resync");
    sb(8'h04, 1, 0, 0, 0, "rl.count2");
    rx_bit(1'b0);
    rx_bit(1'b1);
    rx_bit(1'b0);
    #1 reset = 1'b1;
    e_ram = '0;
    @(posedge clk);
    #1;
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, "midreset");
    chk_cnt++;
    wait_drain(20, "midreset");
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    wait_drain(200, "final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/td4_loader.md
# td4_loader

Serial program loader and program store for the TD4 core. It receives a framed program over a UART line and writes it into a 16 x 8 program RAM, which the core fetches from asynchronously. The core is held in reset while a load is in progress. The loader sits between the board UART pin and the core's instruction-fetch port, and replaces the fixed ROM.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clk cycles per UART bit; must be ≥ 4.
- SYNC_BYTE, default 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  UART receive line, 8N1, LSB first, idle high; asynchronous to clk.
- cpu_addr  input  4  core fetch address.
- cpu_data  output  8  instruction at cpu_addr.
- cpu_reset  output  1  held high to keep the core in reset.
- load_done  output  1  last frame committed; core running.
- load_err  output  1  last frame aborted (framing, count or checksum error).

## Operation
- **Read path:** cpu_data = ram[cpu_addr], combinational, no clock.
- **rx synchronizer:** rx passes through a 2-FF synchronizer; everything downstream uses the synchronized value.

**Byte receiver**
- **Start:** a synchronized falling edge while idle starts a frame.
- **Start check:** the start bit is re-checked at CLKS_PER_BIT/2. If rx is high there, the receiver returns to idle silently (glitch).
- **Data:** 8 data bits are sampled every CLKS_PER_BIT cycles after the start-bit centre, LSB first.
- **Stop:** the stop bit is sampled at its centre.
  - Stop = 1: byte_valid pulses for 1 cycle, together with the byte.
  - Stop = 0: framing error. No byte_valid is issued; the parser is told to abort.

**Parser FSM** (states: WAIT_SYNC, GET_COUNT, GET_DATA, GET_SUM, RUN)
- **WAIT_SYNC:** bytes other than SYNC_BYTE are ignored. SYNC_BYTE → GET_COUNT, sets cpu_reset=1, clears load_done and load_err.
- **GET_COUNT:**
  - Byte 0 means N=16; bytes 1..16 give N directly.
  - Any value > 16 sets load_err=1 and returns to WAIT_SYNC.
  - On a valid count, the write pointer and checksum are cleared and the FSM goes to GET_DATA.
- **GET_DATA:** each byte is written to ram[ptr]; ptr increments and sum += byte (mod 256). After byte N → GET_SUM (or see Configuration).
- **GET_SUM:**
  - Byte == sum: load_done=1, cpu_reset=0 → RUN.
  - Otherwise: load_err=1, cpu_reset stays 1 → WAIT_SYNC.
- **RUN:** SYNC_BYTE restarts the load exactly as from WAIT_SYNC, re-asserting cpu_reset. Other bytes are ignored.
- **Framing error:** in any state other than RUN, sets load_err=1 and goes to WAIT_SYNC. In RUN it is ignored.
- **Partial loads:** RAM locations ≥ N keep their previous contents. A failed load may leave RAM partially overwritten; the core stays in reset in that case.

## Timing
- **Reset values:** cpu_reset=1, load_done=0, load_err=0, FSM=WAIT_SYNC, receiver idle, all 16 RAM entries = 8'h00.
- **Sampling point:** the synchronizer adds 2 cycles. Bit sampling is therefore centred on (synchronized) bit time ± 1 cycle.
- **byte_valid:** asserted on the cycle after the stop-bit sample.
- **Output updates:** RAM write, state change, cpu_reset, load_done and load_err update on the clock edge after byte_valid.
  - Example: cpu_reset falls 1 cycle after the checksum byte's byte_valid.
- **Read path:** combinational, so a RAM write is visible on cpu_data on the cycle after the write edge.
- **Back-to-back bytes:** a new start edge is accepted immediately after the stop-bit sample.
- **Reset mid-frame:** aborts everything. All outputs return to their reset values and RAM is cleared.

## Configuration
Macro TD4_LOADER_CHECKSUM_EN:
- **Defined:** GET_SUM is present and the frame is SYNC, COUNT, N data bytes, SUM.
- **Undefined:** the frame has no checksum byte.
  - After data byte N, the FSM goes directly to RUN with load_done=1 and cpu_reset=0, on the same edge timing GET_SUM would have used.
  - load_err can then arise only from a bad count or a framing error.

## Test plan
Bench uses CLKS_PER_BIT=8.

1. **Reset state:** reset pulse, then all cpu_addr 0..15 → cpu_data=00, cpu_reset=1, load_done=0, load_err=0.
2. **Good load:** send A5, 03, 12, 34, 56, sum 9C → ram[0..2]=12,34,56, ram[3]=00, cpu_reset=0 and load_done=1 one cycle after the last byte_valid.
3. **Bad checksum:** same as scenario 2 but sum 9D → load_err=1, cpu_reset=1. A following good frame A5, 01, 7F, 7F → load_done=1, load_err=0, ram[0]=7F.
4. **Count 0 = 16 and bad count:** A5, 00, sixteen bytes 01..10, sum 88 → all 16 entries written, load_done=1. A5, 11 → load_err=1, FSM back in WAIT_SYNC.
5. **Line faults:** a framing error (stop bit=0) during GET_DATA → load_err=1, cpu_reset=1. A 2-cycle low glitch on rx → no byte received, no state change.
6. **Reload and reset mid-frame:**
   - While running, send A5 → cpu_reset=1 and load_done=0 one cycle after its byte_valid.
   - Asserting reset mid-frame → RAM all 00 and outputs at their reset values.
